// File: rtl/pwm_decoder.sv
// Measures high time and period of an asynchronous PWM waveform in clk cycles.
// Each completed cycle is reported with a one-cycle valid strobe; a sticky timeout flags a stuck input.
module pwm_decoder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             signal,
  output logic [WIDTH-1:0] high_cnt,
  output logic [WIDTH-1:0] period_cnt,
  output logic             valid,
  output logic             timeout
);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  state_t           state;
  logic             s1, s2, s3;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] high_lat;
  logic             rise;
  logic             fall;

  // s1/s2 form the metastability synchroniser; s3 is the history bit for edge detection.
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  // NOTE: every register here uses <= so all updates see the pre-edge values of cnt/state.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      state      <= IDLE;
      cnt        <= '0;
      high_lat   <= '0;
      high_cnt   <= '0;
      period_cnt <= '0;
      valid      <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      s1    <= signal;
      s2    <= s1;
      s3    <= s2;
      valid <= 1'b0;

      if (!en) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            // No previous edge to measure from, so the first rise only starts the count.
            if (rise) begin
              state <= HIGH;
              cnt   <= CNT_ONE;
            end else begin
              cnt <= '0;
            end
          end

          HIGH: begin
            if (cnt == CNT_MAX) begin
              timeout <= 1'b1;
              state   <= IDLE;
              cnt     <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
              if (fall) begin
                high_lat <= cnt;
                state    <= LOW;
              end
            end
          end

          LOW: begin
            // A rise on the saturating cycle still yields a normal measurement.
            if (rise) begin
              period_cnt <= cnt;
              high_cnt   <= high_lat;
              valid      <= 1'b1;
              timeout    <= 1'b0;
              cnt        <= CNT_ONE;
              state      <= HIGH;
            end else if (cnt == CNT_MAX) begin
              timeout <= 1'b1;
              state   <= IDLE;
              cnt     <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end

          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_decoder.sv
// Directed self-checking bench for pwm_decoder (WIDTH = 8 so the stuck-input timeout is reachable).
`timescale 1ns/1ps
module tb_pwm_decoder;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic             signal;
  logic [WIDTH-1:0] high_cnt;
  logic [WIDTH-1:0] period_cnt;
  logic             valid;
  logic             timeout;

  always #2.5 clk = ~clk;

  pwm_decoder #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .signal     (signal),
    .high_cnt   (high_cnt),
    .period_cnt (period_cnt),
    .valid      (valid),
    .timeout    (timeout)
  );

  int checks = 0;
  int errors = 0;
  int n_valid = 0;
  int base;
  bit mon_chk = 1'b0;
  bit to_seen = 1'b0;
  bit prev_valid = 1'b0;
  int exp_high = 0;
  int exp_period = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pwm(input int hi, input int lo, input int n);
    repeat (n) begin
      signal = 1'b1;
      repeat (hi) tick();
      signal = 1'b0;
      repeat (lo) tick();
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Counts strobes, checks strobe width and, when enabled, every reported measurement.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      n_valid++;
      check("valid_one_cycle", 32'(prev_valid), 0);
      if (mon_chk) begin
        check("mon_high", 32'(high_cnt), exp_high);
        check("mon_period", 32'(period_cnt), exp_period);
      end
    end
    if (timeout === 1'b1) to_seen = 1'b1;
    prev_valid = valid;
  end

  initial begin
    reset  = 1'b1;
    en     = 1'b1;
    signal = 1'b0;
    repeat (3) tick();
    check("rst_valid", 32'(valid), 0);
    check("rst_timeout", 32'(timeout), 0);
    check("rst_high", 32'(high_cnt), 0);
    check("rst_period", 32'(period_cnt), 0);
    reset = 1'b0;
    tick();

    // Ideal 20/60 PWM, 5 periods, with edge-accurate latency check on the second rise.
    exp_high = 20; exp_period = 80; mon_chk = 1'b1; to_seen = 1'b0;
    base = n_valid;
    pwm(20, 60, 1);
    signal = 1'b1;
    tick(); check("lat_edge1", 32'(valid), 0);
    tick(); check("lat_edge2", 32'(valid), 0);
    tick(); check("lat_edge3", 32'(valid), 1);
    check("ideal_high", 32'(high_cnt), 20);
    check("ideal_period", 32'(period_cnt), 80);
    tick(); check("strobe_len", 32'(valid), 0);
    repeat (16) tick();
    signal = 1'b0;
    repeat (60) tick();
    pwm(20, 60, 3);
    check("ideal_count", 32'(n_valid - base), 4);
    check("ideal_no_timeout", 32'(to_seen), 0);

    // Stuck-high input: saturation raises timeout, then a 10/30 PWM recovers.
    pulse_reset();
    base = n_valid;
    exp_high = 10; exp_period = 40;
    signal = 1'b1;
    repeat (257) tick();
    check("stuck_pre_timeout", 32'(timeout), 0);
    tick();
    check("stuck_timeout", 32'(timeout), 1);
    check("stuck_no_valid", 32'(n_valid - base), 0);
    signal = 1'b0;
    repeat (30) tick();
    signal = 1'b1;
    repeat (5) tick();
    check("timeout_kept_on_restart", 32'(timeout), 1);
    repeat (5) tick();
    signal = 1'b0;
    repeat (30) tick();
    signal = 1'b1;
    repeat (3) tick();
    check("recover_valid", 32'(valid), 1);
    check("recover_timeout_clear", 32'(timeout), 0);
    check("recover_high", 32'(high_cnt), 10);
    check("recover_period", 32'(period_cnt), 40);
    repeat (7) tick();
    signal = 1'b0;
    repeat (30) tick();
    pwm(10, 30, 1);
    check("recover_count", 32'(n_valid - base), 2);

    // Enable dropped for 50 cycles in the middle of a high phase.
    pulse_reset();
    exp_high = 20; exp_period = 80;
    pwm(20, 60, 3);
    check("gate_pre_high", 32'(high_cnt), 20);
    signal = 1'b1;
    repeat (10) tick();
    base = n_valid;
    en = 1'b0;
    repeat (10) tick();
    signal = 1'b0;
    repeat (40) tick();
    en = 1'b1;
    check("gate_hold_high", 32'(high_cnt), 20);
    check("gate_hold_period", 32'(period_cnt), 80);
    repeat (20) tick();
    pwm(20, 60, 1);
    check("gate_first_rise_silent", 32'(n_valid - base), 0);
    pwm(20, 60, 1);
    check("gate_resume_count", 32'(n_valid - base), 1);
    check("gate_resume_period", 32'(period_cnt), 80);

    // Reset asserted for one cycle in the middle of a low phase.
    repeat (10) tick();
    reset = 1'b1;
    tick();
    check("midrst_valid", 32'(valid), 0);
    check("midrst_timeout", 32'(timeout), 0);
    check("midrst_high", 32'(high_cnt), 0);
    check("midrst_period", 32'(period_cnt), 0);
    reset = 1'b0;
    base = n_valid;
    pwm(20, 60, 1);
    check("midrst_partial_silent", 32'(n_valid - base), 0);
    pwm(20, 60, 1);
    check("midrst_second_rise", 32'(n_valid - base), 1);

    // Single-sample glitch followed by a 40/100 PWM.
    pulse_reset();
    mon_chk = 1'b0; to_seen = 1'b0;
    base = n_valid;
    signal = 1'b1;
    tick();
    signal = 1'b0;
    repeat (20) tick();
    signal = 1'b1;
    repeat (3) tick();
    check("glitch_valid", 32'(valid), 1);
    check("glitch_high", 32'(high_cnt), 1);
    check("glitch_period", 32'(period_cnt), 21);
    repeat (37) tick();
    signal = 1'b0;
    repeat (60) tick();
    exp_high = 40; exp_period = 100; mon_chk = 1'b1;
    pwm(40, 60, 3);
    check("glitch_count", 32'(n_valid - base), 4);
    check("glitch_no_timeout", 32'(to_seen), 0);
    check("steady_high", 32'(high_cnt), 40);
    check("steady_period", 32'(period_cnt), 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_decoder.md
# pwm_decoder

Measures the photonic-switch drive waveform (`signal`, the PWM output of `top`) in units of the core clock. It is the read-back end of the PWM path: it recovers the high time and period that the generator produced and reports each completed cycle with a one-cycle strobe. It sits on the core clock domain and synchronises `signal`, which is produced from the `clkA`/`clkB` domains.

## Interface
- `WIDTH`, 16: width of the measurement counter and of the `high_cnt` / `period_cnt` outputs.
- `clk`  in  1  core clock (`clkCore`, 200 MHz in bench).
- `reset`  in  1  synchronous, active-high reset; sampled on `clk` rising edge.
- `en`  in  1  measurement enable; synchronous.
- `signal`  in  1  asynchronous PWM waveform to measure.
- `high_cnt`  out  WIDTH  clk cycles `signal` was high in the last completed PWM cycle.
- `period_cnt`  out  WIDTH  clk cycles between the last two rising edges.
- `valid`  out  1  one-cycle strobe: `high_cnt` / `period_cnt` updated this cycle.
- `timeout`  out  1  sticky flag: no rising edge seen within 2^WIDTH-1 cycles.

## Operation
- Synchroniser: `s1 <= signal`, `s2 <= s1`, `s3 <= s2`.
  - `rise = s2 & ~s3`
  - `fall = ~s2 & s3`
- Counter `cnt` (WIDTH bits):
  - Loaded with 1 on the edge ending a `rise` cycle; otherwise increments.
  - During the Nth cycle after a rise detection, `cnt` = N.
  - Saturates at 2^WIDTH-1 and never wraps.
- Internal register `high_lat` (WIDTH bits) captures `cnt` on `fall`.
- FSM states: IDLE, HIGH, LOW.
  - IDLE: `cnt` held at 0. On `rise`, go to HIGH; `cnt` <= 1; no `valid` (no previous edge).
  - HIGH: on `fall`, `high_lat` <= `cnt` and go to LOW.
  - LOW: on `rise`, `period_cnt` <= `cnt`, `high_cnt` <= `high_lat`, `valid` <= 1, `cnt` <= 1, and go to HIGH.
- Saturation: when `cnt` = 2^WIDTH-1 in HIGH or LOW and there is no `rise` that cycle:
  - `timeout` <= 1 and go to IDLE.
  - `high_cnt` / `period_cnt` hold their values.
  - Covers both stuck-high and stuck-low inputs.
- Simultaneous `rise` and saturation: `rise` wins (normal measurement, no timeout).
- `timeout` clears on the next `valid` or on `reset`. It does not clear on entering HIGH from IDLE.
- `en` = 0:
  - FSM forced to IDLE, `cnt` <= 0, `valid` <= 0.
  - `high_cnt`, `period_cnt` and `timeout` hold their values.
  - The synchroniser keeps running.
  - After `en` returns to 1, the first `rise` only restarts measurement.
- `en` and `reset` do not abort the synchroniser pipeline mid-edge beyond clearing it on `reset`.
- Reset values: all outputs 0; `s1`/`s2`/`s3`, `cnt` and `high_lat` are 0; FSM in IDLE.
- Reset mid-measurement discards the partial cycle. The first `valid` after reset needs two rising edges.

## Timing
- `reset` has priority over `en`; `en` has priority over FSM activity.
- Edge-detect latency:
  - `signal` sampled high at edge E0 gives `s1` = 1.
  - `rise` is combinationally high after E1.
  - `valid` is registered high after E2 and lasts exactly one cycle.
- `high_cnt` and `period_cnt` change only on the same edge that raises `valid`. They are stable otherwise.
- Measurement resolution is ±1 clk cycle, because the asynchronous input is sampled.
- Minimum measurable values are high = 1 and period = 2. Shorter pulses filtered by the synchroniser produce no event.
- Throughput: one result per PWM period. No back-pressure; the consumer must capture on `valid`.

## Test plan
- Ideal PWM: `signal` high 20 clk, low 60 clk, synchronous to `clk`, 5 periods.
  - Exactly 4 `valid` pulses, each with `high_cnt` = 20 and `period_cnt` = 80.
  - `timeout` = 0 throughout.
  - First `valid` arrives 3 edges after the second rising edge.
- Real `top` output: `clkA` 12.5 ns, `clkB` 12.35 ns, `A_val` = 79, `B_val` = 80, core 5 ns.
  - `period_cnt` and `high_cnt` match the reference-model duration ±1 on every `valid`.
- Stuck input, WIDTH = 8: one rising edge, then `signal` held high.
  - `timeout` = 1 exactly 255 cycles after the rise detection; FSM in IDLE; no `valid`.
  - A subsequent PWM of 10/30 restores one `valid` per period with `timeout` cleared on the first one.
- Enable gating: drop `en` for 50 cycles in the middle of a high phase.
  - No `valid` during or immediately after the gap.
  - Previous 20/80 values are held.
  - The first `valid` after re-enable needs two rises and is correct.
- Reset mid-LOW phase: assert `reset` for 1 cycle.
  - All outputs 0 on the next edge.
  - The partial cycle produces no `valid`.
- Glitch: a 1-clk high pulse sampled by exactly one clk edge, then a 40/100 PWM.
  - The glitch is either ignored or measured as high = 1.
  - Never a timeout or a stuck FSM.
  - Steady-state 40/100 is reported.
